// File: rtl/verificador_pin_pkg.sv
// Shared definitions for the cashier-stage controllers.
// Contents: the 2-bit state encodings used by the PIN verifier FSM and the
// highest keypad code that counts as a decimal digit.
package verificador_pin_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURA = 2'd1;
    localparam logic [1:0] ST_COMPARA = 2'd2;
    localparam logic [1:0] ST_BLOQUEO = 2'd3;

    localparam int VALID_DIGIT_MAX = 9;

endpackage

// File: rtl/verificador_pin_timer.sv
// Inactivity timer for the cashier stages.
// Down-counter loaded with CICLOS-1 by clr. It decrements on every cycle with en
// high. expirado goes high on the en cycle that finds the count already at zero,
// so it fires on the CICLOS-th consecutive enabled cycle after a clear. clr always
// wins over en. The count itself is not an output.
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-low
//   clr       reload the timer (activity seen)
//   en        count one idle cycle
//   expirado  idle budget used up (combinational, qualified by en)
module verificador_pin_timer
    import verificador_pin_pkg::*;
#(
    parameter int CICLOS = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expirado
);

    localparam int W = (CICLOS > 1) ? $clog2(CICLOS) : 1;
    localparam logic [W-1:0] CARGA = W'(CICLOS - 1);

    logic [W-1:0] cuenta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cuenta <= '0;
        end else if (clr) begin
            cuenta <= CARGA;
        end else if (en && (cuenta != '0)) begin
            cuenta <= cuenta - W'(1);
        end
    end

    assign expirado = en && !clr && (cuenta == '0);

endmodule

// File: rtl/verificador_pin.sv
// PIN verification stage of the automatic cashier.
// When a card is present, this stage collects PIN_DIGITS keypad digits. It compares
// them with the PIN that was latched from the card. It allows MAX_INTENTOS tries
// and then retains the card. It aborts after TIMEOUT_CYC idle cycles. fin pulses
// once for every outcome except a reset.
// Ports:
//   clk, reset           clock / asynchronous active-low reset
//   tarjeta_recibida     card present (level)
//   pin_tarjeta          card PIN, digit 0 in the MSBs, latched on card entry
//   digito, digito_stb   keypad code and its 1-cycle strobe (codes > 9 ignored)
//   pin_correcto         pulse: PIN matched
//   pin_incorrecto       pulse: PIN wrong, another try allowed
//   tiempo_agotado       pulse: inactivity timeout
//   bloqueo              level: card retained until reset
//   intentos_restantes   tries left
//   fin                  pulse: stage finished
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | waiting for a card; latch its PIN on arrival
// CAPTURA  | collecting digits, inactivity timer running
// COMPARA  | one cycle: compare the entered PIN with the latched copy
// BLOQUEO  | card retained; everything ignored until reset
module verificador_pin
    import verificador_pin_pkg::*;
#(
    parameter int PIN_DIGITS   = 4,
    parameter int DIGIT_W      = 4,
    parameter int MAX_INTENTOS = 3,
    parameter int TIMEOUT_CYC  = 1000
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  tarjeta_recibida,
    input  logic [PIN_DIGITS*DIGIT_W-1:0]         pin_tarjeta,
    input  logic [DIGIT_W-1:0]                    digito,
    input  logic                                  digito_stb,
    output logic                                  pin_correcto,
    output logic                                  pin_incorrecto,
    output logic                                  tiempo_agotado,
    output logic                                  bloqueo,
    output logic [$clog2(MAX_INTENTOS+1)-1:0]     intentos_restantes,
    output logic                                  fin
);

    localparam int PIN_W = PIN_DIGITS * DIGIT_W;
    localparam int CNT_W = $clog2(PIN_DIGITS + 1);
    localparam int INT_W = $clog2(MAX_INTENTOS + 1);

    localparam logic [CNT_W-1:0]   ULTIMO  = CNT_W'(PIN_DIGITS - 1);
    localparam logic [INT_W-1:0]   INT_MAX = INT_W'(MAX_INTENTOS);
    localparam logic [INT_W-1:0]   INT_UNO = INT_W'(1);
    localparam logic [DIGIT_W-1:0] DIG_MAX = DIGIT_W'(VALID_DIGIT_MAX);

    logic [1:0]       estado;
    logic [CNT_W-1:0] cuenta_dig;
    logic [PIN_W-1:0] pin_ent;
    logic [PIN_W-1:0] pin_ref;
    logic             valido;
    logic             tmr_clr;
    logic             tmr_en;
    logic             expirado;

    assign valido = digito_stb && (digito <= DIG_MAX);

    // The timer only runs in CAPTURA, so it is held loaded in every other state.
    // That also covers the COMPARA -> CAPTURA retry path.
    assign tmr_clr = (estado != ST_CAPTURA) || valido;
    assign tmr_en  = (estado == ST_CAPTURA) && tarjeta_recibida && !valido;

    verificador_pin_timer #(
        .CICLOS (TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .expirado (expirado)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado             <= ST_IDLE;
            cuenta_dig         <= '0;
            pin_ent            <= '0;
            pin_ref            <= '0;
            intentos_restantes <= INT_MAX;
            bloqueo            <= 1'b0;
            pin_correcto       <= 1'b0;
            pin_incorrecto     <= 1'b0;
            tiempo_agotado     <= 1'b0;
            fin                <= 1'b0;
        end else begin
            pin_correcto   <= 1'b0;
            pin_incorrecto <= 1'b0;
            tiempo_agotado <= 1'b0;
            fin            <= 1'b0;

            case (estado)
                ST_IDLE: begin
                    if (tarjeta_recibida) begin
                        pin_ref            <= pin_tarjeta;
                        intentos_restantes <= INT_MAX;
                        cuenta_dig         <= '0;
                        pin_ent            <= '0;
                        estado             <= ST_CAPTURA;
                    end
                end

                ST_CAPTURA: begin
                    if (!tarjeta_recibida) begin
                        fin    <= 1'b1;
                        estado <= ST_IDLE;
                    end else if (valido) begin
                        // Shift left so the first digit typed ends up in the MSBs, the same as pin_tarjeta.
                        pin_ent    <= (pin_ent << DIGIT_W) | PIN_W'(digito);
                        cuenta_dig <= cuenta_dig + CNT_W'(1);
                        if (cuenta_dig == ULTIMO) begin
                            estado <= ST_COMPARA;
                        end
                    end else if (expirado) begin
                        tiempo_agotado <= 1'b1;
                        fin            <= 1'b1;
                        estado         <= ST_IDLE;
                    end
                end

                ST_COMPARA: begin
                    if (!tarjeta_recibida) begin
                        fin    <= 1'b1;
                        estado <= ST_IDLE;
                    end else if (pin_ent == pin_ref) begin
                        pin_correcto <= 1'b1;
                        fin          <= 1'b1;
                        estado       <= ST_IDLE;
                    end else if (intentos_restantes > INT_UNO) begin
                        intentos_restantes <= intentos_restantes - INT_UNO;
                        pin_incorrecto     <= 1'b1;
                        cuenta_dig         <= '0;
                        estado             <= ST_CAPTURA;
                    end else begin
                        intentos_restantes <= '0;
                        bloqueo            <= 1'b1;
                        fin                <= 1'b1;
                        estado             <= ST_BLOQUEO;
                    end
                end

                ST_BLOQUEO: begin
                    estado <= ST_BLOQUEO;
                end

                default: begin
                    estado <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_verificador_pin.sv
// Bench for verificador_pin at default parameters.
// Output vector = {pin_correcto, pin_incorrecto, tiempo_agotado, fin, bloqueo, intentos_restantes[1:0]}.
module tb_verificador_pin;

    localparam int PIN_DIGITS   = 4;
    localparam int DIGIT_W      = 4;
    localparam int MAX_INTENTOS = 3;
    localparam int TIMEOUT_CYC  = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tarjeta_recibida = 1'b0;
    logic [15:0] pin_tarjeta = 16'h1234;
    logic [3:0]  digito = 4'd0;
    logic        digito_stb = 1'b0;
    logic        pin_correcto;
    logic        pin_incorrecto;
    logic        tiempo_agotado;
    logic        bloqueo;
    logic [1:0]  intentos_restantes;
    logic        fin;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    verificador_pin #(
        .PIN_DIGITS   (PIN_DIGITS),
        .DIGIT_W      (DIGIT_W),
        .MAX_INTENTOS (MAX_INTENTOS),
        .TIMEOUT_CYC  (TIMEOUT_CYC)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .tarjeta_recibida   (tarjeta_recibida),
        .pin_tarjeta        (pin_tarjeta),
        .digito             (digito),
        .digito_stb         (digito_stb),
        .pin_correcto       (pin_correcto),
        .pin_incorrecto     (pin_incorrecto),
        .tiempo_agotado     (tiempo_agotado),
        .bloqueo            (bloqueo),
        .intentos_restantes (intentos_restantes),
        .fin                (fin)
    );

    function automatic logic [6:0] salidas();
        return {pin_correcto, pin_incorrecto, tiempo_agotado, fin, bloqueo, intentos_restantes};
    endfunction

    task automatic chk(input string nombre, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nombre, got, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tecla(input logic [3:0] d);
        digito     = d;
        digito_stb = 1'b1;
        tick();
        digito_stb = 1'b0;
    endtask

    // ---------------- table of cycle vectors ----------------
    typedef struct {
        string      nombre;
        logic       tarjeta;
        logic       stb;
        logic [3:0] dig;
        logic [6:0] esperado;
    } vec_t;

    vec_t tabla[$];

    task automatic add(input string n, input logic t, input logic s, input logic [3:0] d, input logic [6:0] e);
        vec_t v;
        v.nombre   = n;
        v.tarjeta  = t;
        v.stb      = s;
        v.dig      = d;
        v.esperado = e;
        tabla.push_back(v);
    endtask

    // ---------------- behavioural reference model ----------------
    bit m_ses, m_cmp, m_ret;
    bit e_ok, e_bad, e_to, e_fin;
    int m_tries, m_idle, m_pin;
    int m_dig[$];

    task automatic modelo_reset();
        m_ses = 0; m_cmp = 0; m_ret = 0;
        e_ok = 0; e_bad = 0; e_to = 0; e_fin = 0;
        m_tries = MAX_INTENTOS;
        m_idle = 0;
        m_dig.delete();
    endtask

    task automatic modelo_paso(input logic t, input logic [15:0] p, input logic [3:0] d, input logic s);
        int v;
        e_ok = 0; e_bad = 0; e_to = 0; e_fin = 0;
        v = 0;
        if (m_ret) begin
            m_ret = 1;
        end else if (m_cmp) begin
            m_cmp = 0;
            if (!t) begin
                e_fin = 1;
            end else begin
                foreach (m_dig[i]) v = v * 16 + m_dig[i];
                if (v == m_pin) begin
                    e_ok = 1; e_fin = 1;
                end else if (m_tries > 1) begin
                    m_tries--; e_bad = 1; m_dig.delete(); m_idle = 0; m_ses = 1;
                end else begin
                    m_tries = 0; m_ret = 1; e_fin = 1;
                end
            end
        end else if (m_ses) begin
            if (!t) begin
                e_fin = 1; m_ses = 0;
            end else if (s && d <= 4'd9) begin
                m_dig.push_back(int'(d));
                m_idle = 0;
                if (m_dig.size() == PIN_DIGITS) begin
                    m_ses = 0; m_cmp = 1;
                end
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT_CYC) begin
                    e_to = 1; e_fin = 1; m_ses = 0;
                end
            end
        end else if (t) begin
            m_pin = int'(p);
            m_tries = MAX_INTENTOS;
            m_dig.delete();
            m_idle = 0;
            m_ses = 1;
        end
    endtask

    function automatic logic [6:0] modelo_salidas();
        return {e_ok, e_bad, e_to, e_fin, m_ret, 2'(m_tries)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int npul;
        int pos;
        logic [15:0] p;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 32'(salidas()), 32'h03);
        reset = 1'b1;

        // ---------------- table: tests 1, 2, 5, 6 ----------------
        add("entrada1", 1, 0, 4'd0, 7'b0000011);
        add("t1_d1",    1, 1, 4'd1, 7'b0000011);
        add("t1_d2",    1, 1, 4'd2, 7'b0000011);
        add("t1_d3",    1, 1, 4'd3, 7'b0000011);
        add("t1_d4",    1, 1, 4'd4, 7'b0000011);
        add("t1_ok",    1, 0, 4'd0, 7'b1001011);
        add("entrada2", 1, 0, 4'd0, 7'b0000011);
        add("t2_d1",    1, 1, 4'd1, 7'b0000011);
        add("t2_d2",    1, 1, 4'd2, 7'b0000011);
        add("t2_d3",    1, 1, 4'd3, 7'b0000011);
        add("t2_d5",    1, 1, 4'd5, 7'b0000011);
        add("t2_mal",   1, 0, 4'd0, 7'b0100010);
        add("t2_r1",    1, 1, 4'd1, 7'b0000010);
        add("t2_r2",    1, 1, 4'd2, 7'b0000010);
        add("t2_r3",    1, 1, 4'd3, 7'b0000010);
        add("t2_r4",    1, 1, 4'd4, 7'b0000010);
        add("t2_ok",    1, 0, 4'd0, 7'b1001010);
        add("t2_fuera", 0, 0, 4'd0, 7'b0000010);
        add("entrada5", 1, 0, 4'd0, 7'b0000011);
        add("t5_d1",    1, 1, 4'd1, 7'b0000011);
        add("t5_dA",    1, 1, 4'hA, 7'b0000011);
        add("t5_d2",    1, 1, 4'd2, 7'b0000011);
        add("t5_dF",    1, 1, 4'hF, 7'b0000011);
        add("t5_d3",    1, 1, 4'd3, 7'b0000011);
        add("t5_d4",    1, 1, 4'd4, 7'b0000011);
        add("t5_ok",    1, 0, 4'd0, 7'b1001011);
        add("t5_fuera", 0, 0, 4'd0, 7'b0000011);
        add("entrada6", 1, 0, 4'd0, 7'b0000011);
        add("t6_d1",    1, 1, 4'd1, 7'b0000011);
        add("t6_d2",    1, 1, 4'd2, 7'b0000011);
        add("t6_d3",    1, 1, 4'd3, 7'b0000011);
        add("t6_retira_con_stb", 0, 1, 4'd4, 7'b0001011);
        add("t6_idle",  0, 0, 4'd0, 7'b0000011);
        add("entrada7", 1, 0, 4'd0, 7'b0000011);
        add("t7_d1",    1, 1, 4'd1, 7'b0000011);
        add("t7_d2",    1, 1, 4'd2, 7'b0000011);
        add("t7_d3",    1, 1, 4'd3, 7'b0000011);
        add("t7_d4",    1, 1, 4'd4, 7'b0000011);
        add("t7_retira_en_compara", 0, 0, 4'd0, 7'b0001011);
        add("t7_idle",  0, 0, 4'd0, 7'b0000011);

        foreach (tabla[i]) begin
            tarjeta_recibida = tabla[i].tarjeta;
            digito_stb       = tabla[i].stb;
            digito           = tabla[i].dig;
            tick();
            chk(tabla[i].nombre, 32'(salidas()), 32'(tabla[i].esperado));
        end
        digito_stb = 1'b0;

        // ---------------- test 3: lockout ----------------
        reset = 1'b0; #1; reset = 1'b1;
        tarjeta_recibida = 1'b1;
        tick();
        for (int a = 1; a <= 3; a++) begin
            for (int i = 0; i < 4; i++) tecla(4'd9);
            tick();
            if (a < 3) chk($sformatf("incorrecto_%0d", a), 32'(salidas()), 32'(7'b0100000 | 7'(3 - a)));
            else       chk("bloqueo_entrada", 32'(salidas()), 32'(7'b0001100));
        end
        tarjeta_recibida = 1'b0;
        for (int i = 0; i < 20; i++) begin
            digito     = 4'($urandom_range(0, 15));
            digito_stb = 1'b1;
            tick();
            chk("bloqueo_mantenido", 32'(salidas()), 32'(7'b0000100));
        end
        digito_stb = 1'b0;
        #2; reset = 1'b0; #1;
        chk("reset_async_bloqueo", 32'(salidas()), 32'h03);
        reset = 1'b1;

        // ---------------- test 4: timeout ----------------
        tarjeta_recibida = 1'b1;
        tick();
        tecla(4'd1);
        tecla(4'd2);
        k = 0;
        while (k < 1100) begin
            tick();
            k++;
            if (tiempo_agotado) break;
        end
        chk("timeout_ciclos", 32'(k), 32'd1000);
        chk("timeout_salidas", 32'(salidas()), 32'(7'b0011011));
        tarjeta_recibida = 1'b0;
        tick();
        chk("timeout_idle", 32'(salidas()), 32'h03);

        // strobe on the would-be timeout cycle wins; invalid strobes do not reload
        tarjeta_recibida = 1'b1;
        tick();
        tecla(4'd1);
        npul = 0;
        repeat (999) begin
            tick();
            if (tiempo_agotado || fin) npul++;
        end
        chk("sin_timeout_previo", 32'(npul), 32'd0);
        tecla(4'd2);
        chk("strobe_gana_timeout", 32'(salidas()), 32'h03);
        digito     = 4'hA;
        digito_stb = 1'b1;
        npul = 0;
        repeat (999) begin
            tick();
            if (tiempo_agotado || fin) npul++;
        end
        chk("invalido_sin_pulso", 32'(npul), 32'd0);
        tick();
        chk("invalido_no_recarga", 32'(salidas()), 32'(7'b0011011));
        digito_stb = 1'b0;
        tarjeta_recibida = 1'b0;
        tick();

        // ---------------- async reset mid-CAPTURA ----------------
        tarjeta_recibida = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tecla(4'd0);
        tick();
        chk("incorrecto_previo", 32'(salidas()), 32'(7'b0100010));
        tecla(4'd1);
        tecla(4'd2);
        #2; reset = 1'b0; #1;
        chk("reset_async_captura", 32'(salidas()), 32'h03);
        reset = 1'b1;
        tarjeta_recibida = 1'b0;
        tick();
        chk("tras_reset_idle", 32'(salidas()), 32'h03);

        // ---------------- randomized run against the model ----------------
        reset = 1'b0; #1;
        modelo_reset();
        reset = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (m_ret && $urandom_range(0, 9) == 0) begin
                reset = 1'b0; #1;
                modelo_reset();
                chk("aleatorio_reset", 32'(salidas()), 32'(modelo_salidas()));
                reset = 1'b1;
            end
            tarjeta_recibida = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < 4; i++) p[i*4 +: 4] = 4'($urandom_range(0, 9));
                pin_tarjeta = p;
            end
            digito_stb = ($urandom_range(0, 2) != 0);
            pos = m_dig.size();
            if (pos < 4 && $urandom_range(0, 3) != 0) digito = 4'((m_pin >> (4 * (3 - pos))) & 15);
            else                                      digito = 4'($urandom_range(0, 15));
            modelo_paso(tarjeta_recibida, pin_tarjeta, digito, digito_stb);
            tick();
            chk("aleatorio", 32'(salidas()), 32'(modelo_salidas()));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
